// File: rtl/dma_host_pkg.sv
// Shared definitions for the dma_host word-copy engine: register map,
// CTRL/STATUS bit positions and the transfer FSM state type.
package dma_host_pkg;

  // Word index of each register (dev_addr_i[4:2])
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ABORT   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_ABORTED = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
  } dma_state_e;

endpackage

// File: rtl/dma_host_regs.sv
// Device-side register window of dma_host: SRC/DST/LEN/CTRL/STATUS, W1C status
// and the registered interrupt. ABORT/ABORTED exist only with DMA_HOST_ABORT_EN.
module dma_host_regs
  import dma_host_pkg::*;
#(
  parameter int LenWidth  = 16,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  input  logic                 busy_i,
  input  logic                 done_set_i,
  input  logic                 err_set_i,
  input  logic                 aborted_set_i,
  output logic                 start_o,
  output logic                 abort_o,
  output logic [AddrWidth-1:0] src_o,
  output logic [AddrWidth-1:0] dst_o,
  output logic [LenWidth-1:0]  len_o,
  output logic                 irq_o
);

  logic [AddrWidth-1:0] src_q, dst_q;
  logic [LenWidth-1:0]  len_q;
  logic                 irq_en_q, done_q, err_q, irq_q, rvalid_q;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 aborted;
  logic [2:0]           reg_idx;
  logic                 wr_src, wr_dst, wr_len, wr_ctrl, wr_status;
  logic                 unused_addr;

  assign reg_idx     = dev_addr_i[4:2];
  assign unused_addr = ^{dev_addr_i[AddrWidth-1:5], dev_addr_i[1:0]};

  assign wr_src    = dev_req_i & dev_we_i & (reg_idx == REG_SRC);
  assign wr_dst    = dev_req_i & dev_we_i & (reg_idx == REG_DST);
  assign wr_len    = dev_req_i & dev_we_i & (reg_idx == REG_LEN);
  assign wr_ctrl   = dev_req_i & dev_we_i & (reg_idx == REG_CTRL);
  assign wr_status = dev_req_i & dev_we_i & (reg_idx == REG_STATUS);

  assign start_o = wr_ctrl & dev_wdata_i[CTRL_START] & ~busy_i;

`ifdef DMA_HOST_ABORT_EN
  logic aborted_q;

  assign abort_o = wr_ctrl & dev_wdata_i[CTRL_ABORT] & busy_i;
  assign aborted = aborted_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aborted_q <= 1'b0;
    end else begin
      if (start_o) aborted_q <= 1'b0;
      if (wr_status && dev_wdata_i[STAT_ABORTED]) aborted_q <= 1'b0;
      if (aborted_set_i) aborted_q <= 1'b1;
    end
  end
`else
  logic unused_abort;

  assign abort_o      = 1'b0;
  assign aborted      = 1'b0;
  assign unused_abort = aborted_set_i;
`endif

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = '0;
    if (dev_req_i && !dev_we_i) begin
      case (reg_idx)
        REG_SRC:    rdata_d[AddrWidth-1:0] = src_q;
        REG_DST:    rdata_d[AddrWidth-1:0] = dst_q;
        REG_LEN:    rdata_d[LenWidth-1:0]  = len_q;
        REG_CTRL:   rdata_d[CTRL_IRQ_EN]   = irq_en_q;
        REG_STATUS: begin
          rdata_d[STAT_BUSY]    = busy_i;
          rdata_d[STAT_DONE]    = done_q;
          rdata_d[STAT_ERR]     = err_q;
          rdata_d[STAT_ABORTED] = aborted;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= dev_req_i;
      rdata_q  <= rdata_d;
      if (!busy_i) begin
        if (wr_src) src_q <= {dev_wdata_i[AddrWidth-1:2], 2'b00};
        if (wr_dst) dst_q <= {dev_wdata_i[AddrWidth-1:2], 2'b00};
        if (wr_len) len_q <= dev_wdata_i[LenWidth-1:0];
      end
      if (wr_ctrl) irq_en_q <= dev_wdata_i[CTRL_IRQ_EN];
      // Clears come first so a same-cycle set from the engine wins.
      if (wr_status && dev_wdata_i[STAT_DONE]) done_q <= 1'b0;
      if (wr_status && dev_wdata_i[STAT_ERR])  err_q  <= 1'b0;
      if (start_o) begin
        done_q <= (len_q == '0);
        err_q  <= 1'b0;
      end
      if (done_set_i) done_q <= 1'b1;
      if (err_set_i)  err_q  <= 1'b1;
      irq_q <= irq_en_q & (done_q | err_q | aborted);
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign src_o        = src_q;
  assign dst_o        = dst_q;
  assign len_o        = len_q;
  assign irq_o        = irq_q;

endmodule

// File: rtl/dma_host.sv
// Single-channel word-copy DMA: copies LEN words SRC->DST over the host bus,
// one outstanding transaction at a time. Optional abort: DMA_HOST_ABORT_EN.
module dma_host
  import dma_host_pkg::*;
#(
  parameter int LenWidth  = 16,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [3:0]           dev_be_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o
);

  dma_state_e           state_q;
  logic [AddrWidth-1:0] src_cur_q, dst_cur_q, addr_q;
  logic [LenWidth-1:0]  cnt_q;
  logic [DataWidth-1:0] buf_q;
  logic                 req_q, we_q;

  logic                 start, abort_req, abort_hit;
  logic                 done_set, err_set, aborted_set, busy;
  logic                 wait_st, req_st;
  logic [AddrWidth-1:0] src_cfg, dst_cfg;
  logic [LenWidth-1:0]  len_cfg;
  logic                 unused_be;

  assign unused_be = ^dev_be_i;
  assign busy      = (state_q != ST_IDLE);
  assign wait_st   = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
  assign req_st    = (state_q == ST_RD_REQ)  || (state_q == ST_WR_REQ);

  assign err_set  = wait_st & host_rvalid_i & host_err_i;
  assign done_set = (state_q == ST_WR_WAIT) & host_rvalid_i & ~host_err_i
                  & ~abort_hit & (cnt_q == LenWidth'(1));

`ifdef DMA_HOST_ABORT_EN
  logic abort_pend_q;

  // Remembers an abort that landed while a response is still owed.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == ST_IDLE) abort_pend_q <= 1'b0;
    else if (wait_st && host_rvalid_i) abort_pend_q <= 1'b0;
    else if (abort_req)                abort_pend_q <= 1'b1;
  end

  assign abort_hit   = abort_req | abort_pend_q;
  assign aborted_set = (req_st & abort_req & ~host_gnt_i)
                     | (wait_st & host_rvalid_i & abort_hit);
`else
  assign abort_hit   = abort_req;
  assign aborted_set = 1'b0;
`endif

  dma_host_regs #(
    .LenWidth (LenWidth),
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) u_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dev_req_i    (dev_req_i),
    .dev_we_i     (dev_we_i),
    .dev_addr_i   (dev_addr_i),
    .dev_wdata_i  (dev_wdata_i),
    .dev_rvalid_o (dev_rvalid_o),
    .dev_rdata_o  (dev_rdata_o),
    .busy_i       (busy),
    .done_set_i   (done_set),
    .err_set_i    (err_set),
    .aborted_set_i(aborted_set),
    .start_o      (start),
    .abort_o      (abort_req),
    .src_o        (src_cfg),
    .dst_o        (dst_cfg),
    .len_o        (len_cfg),
    .irq_o        (irq_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      src_cur_q <= '0;
      dst_cur_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && len_cfg != '0) begin
            src_cur_q <= src_cfg;
            dst_cur_q <= dst_cfg;
            cnt_q     <= len_cfg;
            addr_q    <= src_cfg;
            req_q     <= 1'b1;
            we_q      <= 1'b0;
            state_q   <= ST_RD_REQ;
          end
        end
        ST_RD_REQ, ST_WR_REQ: begin
          if (host_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= (state_q == ST_RD_REQ) ? ST_RD_WAIT : ST_WR_WAIT;
          end else if (abort_req) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (host_rvalid_i) begin
            buf_q <= host_rdata_i;
            if (host_err_i || abort_hit) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q  <= dst_cur_q;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              state_q <= ST_WR_REQ;
            end
          end
        end
        ST_WR_WAIT: begin
          if (host_rvalid_i) begin
            we_q <= 1'b0;
            if (host_err_i || abort_hit) begin
              state_q <= ST_IDLE;
            end else begin
              src_cur_q <= src_cur_q + AddrWidth'(4);
              dst_cur_q <= dst_cur_q + AddrWidth'(4);
              cnt_q     <= cnt_q - LenWidth'(1);
              if (cnt_q == LenWidth'(1)) begin
                state_q <= ST_IDLE;
              end else begin
                addr_q  <= src_cur_q + AddrWidth'(4);
                req_q   <= 1'b1;
                state_q <= ST_RD_REQ;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_req_o   = req_q;
  assign host_we_o    = we_q;
  assign host_addr_o  = addr_q;
  assign host_wdata_o = buf_q;
  assign host_be_o    = 4'b1111;

endmodule
